// File: rtl/part3_mult.sv
// part3_mult: sequential shift-add unsigned multiplier with a Go/ResultValid handshake.
// A Go request loads the operands. The unit then runs one add-and-shift step per
// clock and holds the 2N-bit product in DONE until Go is released.
// Optional feature macro: MULT_EARLY_TERM_EN. When it is defined, the unit leaves
// ADD_SHIFT as soon as the remaining multiplier bits are all zero.
module part3_mult #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Go,
  input  logic [N-1:0]   Multiplicand,
  input  logic [N-1:0]   Multiplier,
  output logic [2*N-1:0] Product,
  output logic           ResultValid
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    ADD_SHIFT = 2'b10,
    DONE      = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [2*N-1:0]  p_q, p_d;
  logic [2*N-1:0]  mc_q, mc_d;
  logic [N-1:0]    mq_q, mq_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_step;

`ifdef MULT_EARLY_TERM_EN
  // Stop after the step that shifts the last set multiplier bit out.
  // Any further steps would only add zero to the product.
  assign last_step = (count_q == LAST_COUNT) || (mq_q[N-1:1] == '0);
`else
  // Run exactly N steps, whatever the operands are.
  assign last_step = (count_q == LAST_COUNT);
`endif

  // Next-state logic and datapath updates. Registers hold unless a state below changes them.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    mc_d    = mc_q;
    mq_d    = mq_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (Go) state_d = LOAD;
      end
      LOAD: begin
        p_d     = '0;
        mc_d    = {{N{1'b0}}, Multiplicand};
        mq_d    = Multiplier;
        count_d = '0;
        state_d = ADD_SHIFT;
      end
      ADD_SHIFT: begin
        p_d     = p_q + (mq_q[0] ? mc_q : '0);
        mc_d    = mc_q << 1;
        mq_d    = mq_q >> 1;
        count_d = count_q + 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (!Go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. An active-low synchronous reset discards any partial result.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      p_q     <= '0;
      mc_q    <= '0;
      mq_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mc_q    <= mc_d;
      mq_q    <= mq_d;
      count_q <= count_d;
    end
  end

  // Outputs decode registered state only. Product reads zero outside DONE.
  assign ResultValid = (state_q == DONE);
  assign Product     = (state_q == DONE) ? p_q : '0;

endmodule

// File: tb/tb_part3_mult.sv
// tb_part3_mult: self-checking bench for part3_mult.
// Each check compares the unit against a reference model: the product is a*b, and
// the latency comes from a formula. Stimulus is a mix of directed and random operations.
module tb_part3_mult;
  localparam int N = 4;

  logic           Clock;
  logic           Resetn;
  logic           Go;
  logic [N-1:0]   Multiplicand;
  logic [N-1:0]   Multiplier;
  logic [2*N-1:0] Product;
  logic           ResultValid;

  int tests_run = 0;
  int tests_failed = 0;

  part3_mult #(.N(N)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Go           (Go),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .ResultValid  (ResultValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Latency is the number of edges from raising Go until ResultValid is first seen high.
  function automatic int model_latency(input int b);
`ifdef MULT_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < N; i++) if (((b >> i) & 1) == 1) msb = i;
    return 2 + ((msb + 1) < 1 ? 1 : (msb + 1));
`else
    return N + 2;
`endif
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one operation. With hold=1, Go stays high through DONE.
  // With scramble=1, the operands are changed after they have been loaded.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit hold, input bit scramble, input string tag);
    int lat;
    int exp_lat;
    longint exp_p;
    exp_p   = longint'(a) * longint'(b);
    exp_lat = model_latency(int'(b));
    lat     = 0;
    @(posedge Clock); #1;
    Go = 1'b1; Multiplicand = a; Multiplier = b;
    for (int k = 1; k <= 3 * N + 10; k++) begin
      @(posedge Clock); #1;
      if (!hold && k == 1) Go = 1'b0;
      if (k == 1) check({tag, "_prod_zero_in_load"}, longint'(Product), 0);
      if (scramble && k == 2) begin
        Multiplicand = N'($urandom);
        Multiplier   = N'($urandom);
      end
      if (ResultValid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, longint'(Product), exp_p);
    if (hold) begin
      for (int k = 0; k < 20; k++) begin
        @(posedge Clock); #1;
        check({tag, "_hold_valid"}, longint'(ResultValid), 1);
        check({tag, "_hold_product"}, longint'(Product), exp_p);
      end
      Go = 1'b0;
    end
    @(posedge Clock); #1;
    check({tag, "_release_valid"}, longint'(ResultValid), 0);
    check({tag, "_release_product"}, longint'(Product), 0);
    $display("[TB] %s: %0d x %0d -> product %0d latency %0d (expected %0d, %0d)",
             tag, a, b, Product, lat, exp_p, exp_lat);
  endtask

  initial begin
    Resetn = 1'b0; Go = 1'b0; Multiplicand = '0; Multiplier = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_valid", longint'(ResultValid), 0);
    check("reset_product", longint'(Product), 0);
    Resetn = 1'b1;

    // Directed operations.
    do_op(4'd13, 4'd11, 1'b0, 1'b0, "basic_13x11");
    do_op(4'd15, 4'd15, 1'b0, 1'b0, "corner_15x15");
    do_op(4'd0,  4'd9,  1'b0, 1'b0, "corner_0x9");
    do_op(4'd1,  4'd15, 1'b0, 1'b0, "corner_1x15");
    do_op(4'd9,  4'd2,  1'b0, 1'b0, "early_9x2");
    do_op(4'd9,  4'd0,  1'b0, 1'b0, "early_9x0");
    do_op(4'd9,  4'd8,  1'b0, 1'b0, "early_9x8");

    // Go held high through DONE, then a fresh operation after Go is released.
    do_op(4'd6, 4'd7, 1'b1, 1'b0, "gohold_6x7");
    do_op(4'd5, 4'd3, 1'b1, 1'b0, "gohold_5x3");

    // Operands change after they have been loaded.
    do_op(4'd12, 4'd10, 1'b0, 1'b1, "opchange_12x10");

    // Reset is applied during the second ADD_SHIFT cycle.
    @(posedge Clock); #1;
    Go = 1'b1; Multiplicand = 4'd15; Multiplier = 4'd15;
    @(posedge Clock); #1;  // state is now LOAD
    Go = 1'b0;
    @(posedge Clock); #1;  // first ADD_SHIFT cycle
    @(posedge Clock); #1;  // second ADD_SHIFT cycle
    Resetn = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    check("midreset_valid", longint'(ResultValid), 0);
    check("midreset_product", longint'(Product), 0);
    repeat (N + 3) begin
      @(posedge Clock); #1;
      check("midreset_stays_idle", longint'(ResultValid), 0);
    end
    $display("[TB] mid-operation reset: valid %0d product %0d", ResultValid, Product);
    do_op(4'd7, 4'd3, 1'b0, 1'b0, "after_reset_7x3");

    // Random operations, some of them with operands changed after loading.
    for (int i = 0; i < 24; i++) begin
      do_op(N'($urandom), N'($urandom), 1'b0, bit'($urandom_range(0, 1)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
